imem_loadable: RTL and testbench

- Parametrised, writable successor to the fixed instruction ROM in front of the MIPS fetch stage.
- Keeps the registered-address / 1-cycle fetch timing of the ROM.
- Adds: configurable depth and width; fetch stall hold; out-of-range detection; an auto-incrementing streaming load port, so a bootloader (UART/DMA) can write programs at run time instead of rebuilding a hard-coded case table.

---
 rtl/imem_loadable.sv | 133 +++++++++++++
 tb/tb_imem_loadable.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// Writable instruction memory with registered fetch address and auto-incrementing load port.
// Optional build macro IMEM_CLEAR_ON_RESET_EN: zero-fill the whole array after every reset.
module imem_loadable #(
   parameter int unsigned ADDR_WIDTH = 30,
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   input  logic                  fetch_stall,
   output logic [DATA_WIDTH-1:0] inst,
   output logic                  inst_valid,
   output logic                  oob,
   input  logic                  ld_start,
   input  logic [DEPTH_LOG2-1:0] ld_base,
   input  logic                  ld_valid,
   input  logic [DATA_WIDTH-1:0] ld_data,
   output logic                  ld_ready,
   output logic [DEPTH_LOG2-1:0] ld_ptr,
   output logic                  ld_wrap,
   output logic                  init_busy
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

`ifdef IMEM_CLEAR_ON_RESET_EN
   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_t;
   localparam state_t ST_RESET = ST_CLEAR;
`else
   typedef enum logic [0:0] {ST_RUN = 1'b0} state_t;
   localparam state_t ST_RESET = ST_RUN;
`endif

   state_t                  state_r, state_nxt;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [DEPTH_LOG2-1:0]   ld_ptr_r, ld_ptr_nxt;
   logic                    ld_wrap_r, ld_wrap_nxt;
   logic                    inst_valid_r;
   logic                    run;
   logic                    ld_wr;
   logic [DEPTH_LOG2-1:0]   ptr_sel;
   logic [DEPTH_LOG2-1:0]   ptr_inc;
   logic                    mem_we;
   logic [DEPTH_LOG2-1:0]   mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
`ifdef IMEM_CLEAR_ON_RESET_EN
   logic [DEPTH_LOG2-1:0]   clr_cnt_r;
`endif

   assign run = (state_r == ST_RUN);

   always_comb begin
      state_nxt = state_r;
`ifdef IMEM_CLEAR_ON_RESET_EN
      if (state_r == ST_CLEAR && clr_cnt_r == LAST_IDX) state_nxt = ST_RUN;
`endif
   end

   // ld_start retargets the pointer even when a word is accepted in the same cycle
   always_comb begin
      ld_wr       = ld_valid & run;
      ptr_sel     = ld_start ? ld_base : ld_ptr_r;
      ptr_inc     = ptr_sel + 1'b1;
      ld_ptr_nxt  = ld_ptr_r;
      ld_wrap_nxt = ld_wrap_r;
      if (ld_start) begin
         ld_ptr_nxt  = ld_base;
         ld_wrap_nxt = 1'b0;
      end
      if (ld_wr) begin
         ld_ptr_nxt = ptr_inc;
         if (ptr_sel == LAST_IDX) ld_wrap_nxt = 1'b1;
      end
   end

   always_comb begin
      mem_we    = ld_wr;
      mem_waddr = ptr_sel;
      mem_wdata = ld_data;
`ifdef IMEM_CLEAR_ON_RESET_EN
      if (state_r == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt_r;
         mem_wdata = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_RESET;
         addr_r       <= RESET_VECTOR;
         ld_ptr_r     <= '0;
         ld_wrap_r    <= 1'b0;
         inst_valid_r <= 1'b0;
`ifdef IMEM_CLEAR_ON_RESET_EN
         clr_cnt_r    <= '0;
`endif
      end else begin
         state_r   <= state_nxt;
         ld_ptr_r  <= ld_ptr_nxt;
         ld_wrap_r <= ld_wrap_nxt;
         if (run && !fetch_stall) addr_r <= fetch_addr;
         if (run) inst_valid_r <= 1'b1;
`ifdef IMEM_CLEAR_ON_RESET_EN
         if (state_r == ST_CLEAR) clr_cnt_r <= clr_cnt_r + 1'b1;
`endif
      end
   end

   // Array has no reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Read is combinational from the registered address, which gives write-first on collision
   assign oob        = |addr_r[ADDR_WIDTH-1:DEPTH_LOG2];
   assign inst       = oob ? '0 : mem[addr_r[DEPTH_LOG2-1:0]];
   assign inst_valid = inst_valid_r;
   assign ld_ready   = run;
   assign ld_ptr     = ld_ptr_r;
   assign ld_wrap    = ld_wrap_r;
`ifdef IMEM_CLEAR_ON_RESET_EN
   assign init_busy  = (state_r == ST_CLEAR);
`else
   assign init_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Directed + randomized bench for imem_loadable against an array-based reference model.
// Covers the IMEM_CLEAR_ON_RESET_EN build when that macro is defined.
module tb_imem_loadable;

   localparam int unsigned AW = 30;
   localparam int unsigned DL = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned DEPTH = 16;
`ifdef IMEM_CLEAR_ON_RESET_EN
   localparam int CLR_CYCLES = 16;
`else
   localparam int CLR_CYCLES = 0;
`endif

   logic          clk;
   logic          rst;
   logic [AW-1:0] fetch_addr;
   logic          fetch_stall;
   logic [DW-1:0] inst;
   logic          inst_valid;
   logic          oob;
   logic          ld_start;
   logic [DL-1:0] ld_base;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic [DL-1:0] ld_ptr;
   logic          ld_wrap;
   logic          init_busy;

   imem_loadable #(
      .ADDR_WIDTH  (AW),
      .DEPTH_LOG2  (DL),
      .DATA_WIDTH  (DW),
      .RESET_VECTOR(30'd0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fetch_addr (fetch_addr),
      .fetch_stall(fetch_stall),
      .inst       (inst),
      .inst_valid (inst_valid),
      .oob        (oob),
      .ld_start   (ld_start),
      .ld_base    (ld_base),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .ld_ptr     (ld_ptr),
      .ld_wrap    (ld_wrap),
      .init_busy  (init_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: plain array plus pointer arithmetic modulo DEPTH
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_known [DEPTH];
   longint unsigned m_addr;
   int unsigned   m_ptr;
   bit            m_wrap;
   bit            m_valid;
   int            m_clear_left;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_addr = 0;
      m_ptr = 0;
      m_wrap = 0;
      m_valid = 0;
      m_clear_left = CLR_CYCLES;
   endtask

   task automatic model_edge();
      int unsigned base;
      base = ld_start ? int'(ld_base) : m_ptr;
      if (ld_start) begin
         m_ptr = ld_base;
         m_wrap = 0;
      end
      if (m_clear_left > 0) begin
         m_mem[DEPTH - m_clear_left] = '0;
         m_known[DEPTH - m_clear_left] = 1;
         m_clear_left--;
      end else begin
         if (!fetch_stall) m_addr = fetch_addr;
         if (ld_valid) begin
            m_mem[base] = ld_data;
            m_known[base] = 1;
            m_ptr = (base + 1) % DEPTH;
            if (base + 1 == DEPTH) m_wrap = 1;
         end
         m_valid = 1;
      end
   endtask

   task automatic check_all();
      chk("inst_valid", 32'(inst_valid), 32'(m_valid));
      chk("oob", 32'(oob), 32'(m_addr >= DEPTH));
      chk("ld_ptr", 32'(ld_ptr), m_ptr);
      chk("ld_wrap", 32'(ld_wrap), 32'(m_wrap));
      chk("ld_ready", 32'(ld_ready), 32'(m_clear_left == 0));
      chk("init_busy", 32'(init_busy), 32'(m_clear_left > 0));
      if (m_addr >= DEPTH) chk("inst_oob", inst, '0);
      else if (m_known[m_addr]) chk("inst", inst, m_mem[m_addr]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      fetch_stall = 0;
      ld_start = 0;
      ld_valid = 0;
      ld_base = '0;
      ld_data = '0;
   endtask

   // Reset pulse fits between two rising edges, so only the asynchronous path acts
   task automatic do_reset();
      rst = 0;
      #1;
      model_reset();
      check_all();
      #1;
      rst = 1;
   endtask

   task automatic wait_clear_done(output int n);
      n = 0;
      for (int i = 0; i < 40 && init_busy; i++) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] words [4];
      int n;
      words = '{32'h24170014, 32'h3c1d1000, 32'h0c000004, 32'h37bd0100};
      for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 0;

      rst = 0;
      fetch_addr = '0;
      idle_inputs();
      #2;
      model_reset();
      check_all();
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_ld_ptr", 32'(ld_ptr), 32'd0);
      #1;
      rst = 1;
      wait_clear_done(n);
      chk("first_clear_len", n, CLR_CYCLES);

      // Load path
      ld_start = 1; ld_base = 4'd0;
      tick();
      ld_start = 0;
      for (int k = 0; k < 4; k++) begin
         ld_valid = 1; ld_data = words[k];
         tick();
      end
      ld_valid = 0;
      chk("load_ptr", 32'(ld_ptr), 32'd4);
      for (int k = 0; k < 4; k++) begin
         fetch_addr = 30'(k);
         tick();
         chk("load_inst", inst, words[k]);
      end
      chk("load_valid", 32'(inst_valid), 32'd1);

      // Fetch stall, target word preloaded with simultaneous start+write
      ld_start = 1; ld_base = 4'd7; ld_valid = 1; ld_data = 32'h12345678;
      tick();
      idle_inputs();
      chk("start_write_ptr", 32'(ld_ptr), 32'd8);
      fetch_addr = 30'd2;
      tick();
      fetch_stall = 1; fetch_addr = 30'd7;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_hold", inst, 32'h0c000004);
      end
      fetch_stall = 0;
      tick();
      chk("stall_release", inst, 32'h12345678);

      // Out of range
      fetch_addr = 30'h10;
      tick();
      chk("oob_hi", 32'(oob), 32'd1);
      chk("oob_inst", inst, 32'd0);
      fetch_addr = 30'h0F;
      tick();
      chk("oob_edge", 32'(oob), 32'd0);
      fetch_addr = 30'h3FFFFFF3;
      tick();
      chk("oob_top", 32'(oob), 32'd1);

      // Wrap, then write-first collision
      ld_start = 1; ld_base = 4'd14;
      tick();
      ld_start = 0;
      for (int k = 0; k < 3; k++) begin
         ld_valid = 1; ld_data = 32'hA0000000 + 32'(k);
         tick();
      end
      ld_valid = 0;
      chk("wrap_flag", 32'(ld_wrap), 32'd1);
      chk("wrap_ptr", 32'(ld_ptr), 32'd1);
      fetch_addr = 30'd0;
      tick();
      chk("wrap_word0", inst, 32'hA0000002);
      for (int k = 1; k < 5; k++) begin
         ld_valid = 1; ld_data = 32'hB0000000 + 32'(k);
         tick();
      end
      ld_data = 32'hC0FFEE55; fetch_addr = 30'd5;
      tick();
      chk("write_first", inst, 32'hC0FFEE55);
      idle_inputs();
      ld_start = 1; ld_base = 4'd0;
      tick();
      ld_start = 0;
      chk("wrap_cleared", 32'(ld_wrap), 32'd0);

      // Simultaneous start and write
      ld_start = 1; ld_base = 4'd9; ld_valid = 1; ld_data = 32'hAAAA5555;
      tick();
      idle_inputs();
      chk("sim_ptr", 32'(ld_ptr), 32'd10);
      fetch_addr = 30'd9;
      tick();
      chk("sim_inst", inst, 32'hAAAA5555);

      // Reset behaviour of the memory array
      ld_start = 1; ld_base = 4'd3; ld_valid = 1; ld_data = 32'hDEADBEEF;
      tick();
      idle_inputs();
      do_reset();
`ifdef IMEM_CLEAR_ON_RESET_EN
      chk("clear_busy", 32'(init_busy), 32'd1);
      ld_valid = 1; ld_data = 32'hFFFFFFFF;
      wait_clear_done(n);
      ld_valid = 0;
      chk("clear_len", n, 16);
      fetch_addr = 30'd3;
      tick();
      chk("clear_word3", inst, 32'd0);
      do_reset();
      for (int k = 0; k < 7; k++) tick();
      do_reset();
      wait_clear_done(n);
      chk("clear_restart_len", n, 16);
`else
      chk("noclear_busy", 32'(init_busy), 32'd0);
      fetch_addr = 30'd3;
      tick();
      chk("survive_word3", inst, 32'hDEADBEEF);
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         fetch_addr  = ($urandom_range(0, 9) == 0) ? 30'($urandom) : 30'($urandom_range(0, 17));
         fetch_stall = ($urandom_range(0, 3) == 0);
         ld_valid    = 1'($urandom_range(0, 1));
         ld_start    = ($urandom_range(0, 11) == 0);
         ld_base     = 4'($urandom);
         ld_data     = $urandom;
         tick();
      end
      idle_inputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
